// File: rtl/bitfusion_mac.sv
// bitfusion_mac: precision-configurable multiply-accumulate unit.
// A single 2-bit BitBrick slice is reused over time. Each slice of the
// activation is multiplied by the extended weight, and the products are summed
// into a wide product register. The finished product is then added into psum.
// Optional feature macro: BITFUSION_SAT_EN. When it is defined, the accumulate
// saturates to the signed ACC_W range. When it is not defined, the accumulate
// wraps modulo 2^ACC_W.
module bitfusion_mac #(
  parameter int MAX_BITS = 8,
  parameter int ACC_W    = 24
) (
  input  logic                CLK_125MHZ_FPGA,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_BITS-1:0] in,
  input  logic [MAX_BITS-1:0] weight,
  input  logic                s_in,
  input  logic                s_weight,
  input  logic [1:0]          prec_in,
  input  logic [1:0]          prec_weight,
  input  logic                acc_clear,
  output logic [ACC_W-1:0]    psum,
  output logic                psum_valid
);

  localparam int PROD_W = 2 * MAX_BITS + 2;   // full product register width
  localparam int PP_W   = MAX_BITS + 4;       // 3-bit slice x (MAX_BITS+1)-bit weight
  localparam int SLICES = MAX_BITS / 2;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Active operand width for a precision code, clamped to MAX_BITS.
  function automatic int prec_width(input logic [1:0] code);
    int w;
    case (code)
      2'd0:    w = 2;
      2'd1:    w = 4;
      2'd2:    w = 8;
      default: w = MAX_BITS;
    endcase
    return (w > MAX_BITS) ? MAX_BITS : w;
  endfunction

  // Ones over the active LSB-aligned field.
  function automatic logic [MAX_BITS-1:0] field_mask(input int width);
    return {MAX_BITS{1'b1}} >> (MAX_BITS - width);
  endfunction

  // Sign- or zero-extend the active field to MAX_BITS+1 bits; high junk dropped.
  function automatic logic [MAX_BITS:0] extend_op(input logic [MAX_BITS-1:0] v,
                                                  input int width, input logic sgn);
    logic [MAX_BITS-1:0] mask;
    logic [MAX_BITS-1:0] top;
    logic                neg;
    mask = field_mask(width);
    top  = {{(MAX_BITS-1){1'b0}}, 1'b1} << (width - 1);
    neg  = sgn && ((v & top) != {MAX_BITS{1'b0}});
    return neg ? {1'b1, v | ~mask} : {1'b0, v & mask};
  endfunction

  state_t                     state_r, state_n;
  logic                       in_ready_r, psum_valid_r;
  logic [ACC_W-1:0]           psum_r, psum_next_s;
  logic [CNT_W-1:0]           cnt_r, last_r;
  logic [MAX_BITS-1:0]        act_r;
  logic [MAX_BITS:0]          wext_r;
  logic                       s_in_r, clear_r;
  logic signed [PROD_W-1:0]   prod_r, pp_shift_s, prod_next_s;
  logic signed [PP_W-1:0]     pp_s;
  logic [1:0]                 slice_s;
  logic signed [2:0]          slice_ext_s;
  logic                       start_s, last_s;

  // Next-state logic: accept in IDLE, step one slice per cycle in BUSY
  always_comb begin
    state_n = state_r;
    start_s = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_n = BUSY;
          start_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == last_r) begin
          state_n = IDLE;
          last_s  = 1'b1;
        end else begin
          state_n = BUSY;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Slice partial product and accumulate value (the top activation slice may be signed)
  always_comb begin
    slice_s = 2'(act_r >> {cnt_r, 1'b0});
    if (s_in_r && (cnt_r == last_r)) begin
      slice_ext_s = {slice_s[1], slice_s};
    end else begin
      slice_ext_s = {1'b0, slice_s};
    end
    pp_s        = PP_W'(slice_ext_s) * PP_W'($signed(wext_r));
    pp_shift_s  = PROD_W'(pp_s) << {cnt_r, 1'b0};
    prod_next_s = prod_r + pp_shift_s;
    psum_next_s = {ACC_W{1'b0}};
`ifdef BITFUSION_SAT_EN
    begin : sat_acc
      localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
      logic signed [SUM_W-1:0]  base_s, sum_s;
      logic [SUM_W-ACC_W:0]     hi_s;
      if (clear_r) begin
        base_s = {SUM_W{1'b0}};
      end else begin
        base_s = SUM_W'($signed(psum_r));
      end
      sum_s = base_s + SUM_W'(prod_next_s);
      hi_s  = sum_s[SUM_W-1:ACC_W-1];
      if ((&hi_s) || !(|hi_s)) begin
        psum_next_s = sum_s[ACC_W-1:0];
      end else if (sum_s[SUM_W-1]) begin
        psum_next_s = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        psum_next_s = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
`else
    if (clear_r) begin
      psum_next_s = ACC_W'(prod_next_s);
    end else begin
      psum_next_s = psum_r + ACC_W'(prod_next_s);
    end
`endif
  end

  // State, handshake and result-pulse registers
  always_ff @(posedge CLK_125MHZ_FPGA or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      in_ready_r   <= 1'b1;
      psum_valid_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      in_ready_r   <= (state_n == IDLE);
      psum_valid_r <= last_s;
    end
  end

  // Operand capture on transfer, slice stepping, and psum write on the last slice
  always_ff @(posedge CLK_125MHZ_FPGA or posedge rst) begin
    if (rst) begin
      act_r   <= {MAX_BITS{1'b0}};
      wext_r  <= {(MAX_BITS+1){1'b0}};
      last_r  <= {CNT_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      s_in_r  <= 1'b0;
      clear_r <= 1'b0;
      prod_r  <= {PROD_W{1'b0}};
      psum_r  <= {ACC_W{1'b0}};
    end else if (start_s) begin
      act_r   <= in & field_mask(prec_width(prec_in));
      wext_r  <= extend_op(weight, prec_width(prec_weight), s_weight);
      last_r  <= CNT_W'(prec_width(prec_in) / 2 - 1);
      cnt_r   <= {CNT_W{1'b0}};
      s_in_r  <= s_in;
      clear_r <= acc_clear;
      prod_r  <= {PROD_W{1'b0}};
    end else if (state_r == BUSY) begin
      if (last_s) begin
        psum_r <= psum_next_s;
      end else begin
        prod_r <= prod_next_s;
        cnt_r  <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign psum       = psum_r;
  assign psum_valid = psum_valid_r;

endmodule

// File: tb/tb_bitfusion_mac.sv
// Self-checking bench for bitfusion_mac (default ACC_W=24 instance plus an
// ACC_W=16 instance sharing the same stimulus for overflow behaviour).
module tb_bitfusion_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_op = 8'd0, weight = 8'd0;
  logic        s_in = 1'b0, s_weight = 1'b0, acc_clear = 1'b0;
  logic [1:0]  prec_in = 2'd0, prec_weight = 2'd0;
  logic        in_ready, in_ready16, psum_valid, psum_valid16;
  logic [23:0] psum;
  logic [15:0] psum16;

  int     tests = 0;
  int     fails = 0;
  longint exp24 = 0, exp16 = 0;
  longint got24, got16;
  int     lat, low_cnt;
  logic   timeout, ready_at_start, valid_at_start, ready_at_valid;

  always #5 clk = ~clk;

  bitfusion_mac #(.MAX_BITS(8), .ACC_W(24)) dut (
    .CLK_125MHZ_FPGA(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in(in_op), .weight(weight), .s_in(s_in), .s_weight(s_weight),
    .prec_in(prec_in), .prec_weight(prec_weight), .acc_clear(acc_clear),
    .psum(psum), .psum_valid(psum_valid));

  bitfusion_mac #(.MAX_BITS(8), .ACC_W(16)) dut16 (
    .CLK_125MHZ_FPGA(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in(in_op), .weight(weight), .s_in(s_in), .s_weight(s_weight),
    .prec_in(prec_in), .prec_weight(prec_weight), .acc_clear(acc_clear),
    .psum(psum16), .psum_valid(psum_valid16));

  function automatic int prec_w(input logic [1:0] code);
    case (code)
      2'd0:    return 2;
      2'd1:    return 4;
      default: return 8;
    endcase
  endfunction

  function automatic longint field_val(input logic [7:0] raw, input logic [1:0] code,
                                       input logic sgn);
    int     wd;
    longint v;
    wd = prec_w(code);
    v  = longint'(raw) & ((longint'(1) << wd) - 1);
    if (sgn && v >= (longint'(1) << (wd - 1))) v = v - (longint'(1) << wd);
    return v;
  endfunction

  function automatic longint fit(input longint v, input int accw);
    longint m;
    m = longint'(1) << accw;
`ifdef BITFUSION_SAT_EN
    if (v > m / 2 - 1) return m / 2 - 1;
    if (v < -(m / 2)) return -(m / 2);
    return v;
`else
    v = v & (m - 1);
    if (v >= m / 2) v = v - m;
    return v;
`endif
  endfunction

  // Drive one operation, update the reference accumulators, and observe timing.
  task automatic run_op(input logic [7:0] a, input logic [7:0] w, input logic sa,
                        input logic sw, input logic [1:0] pa, input logic [1:0] pw,
                        input logic clr, input bit hold);
    longint p;
    in_op = a; weight = w; s_in = sa; s_weight = sw;
    prec_in = pa; prec_weight = pw; acc_clear = clr; in_valid = 1'b1;
    ready_at_start = in_ready;
    @(posedge clk); #1;
    valid_at_start = psum_valid;
    p = field_val(a, pa, sa) * field_val(w, pw, sw);
    exp24 = fit((clr ? 64'sd0 : exp24) + p, 24);
    exp16 = fit((clr ? 64'sd0 : exp16) + p, 16);
    if (!hold) begin
      in_valid = 1'b0;
      in_op = 8'($urandom); weight = 8'($urandom);
      s_in = 1'($urandom); s_weight = 1'($urandom);
      prec_in = 2'($urandom); prec_weight = 2'($urandom); acc_clear = 1'($urandom);
    end
    low_cnt = in_ready ? 0 : 1;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      lat++;
      if (psum_valid) break;
      if (!in_ready) low_cnt++;
    end
    timeout = !psum_valid;
    got24 = longint'($signed(psum));
    got16 = longint'($signed(psum16));
    ready_at_valid = in_ready;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++;
    if (psum !== 24'd0 || psum16 !== 16'd0) begin
      fails++; $display("FAIL reset_psum got %0d/%0d want 0", psum, psum16);
    end
    tests++;
    if (psum_valid !== 1'b0) begin fails++; $display("FAIL reset_psum_valid got %b want 0", psum_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_4b();
    logic [7:0] av, bv;
    int errs;
    run_op(8'd15, 8'd15, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0);
    tests++;
    if (timeout || got24 != 225) begin fails++; $display("FAIL u4_15x15 got %0d want 225 (timeout=%b)", got24, timeout); end
    tests++;
    if (lat != 2 || low_cnt != 2 || ready_at_valid !== 1'b1) begin
      fails++; $display("FAIL u4_timing lat %0d low %0d ready %b want 2 2 1", lat, low_cnt, ready_at_valid);
    end
    errs = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        av = {4'($urandom), 4'(a)};
        bv = {4'($urandom), 4'(b)};
        run_op(av, bv, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0);
        tests++;
        if (timeout || got24 != longint'(a * b) || lat != 2) begin
          fails++; errs++;
          if (errs < 5) $display("FAIL u4_sweep %0dx%0d got %0d lat %0d want %0d lat 2", a, b, got24, lat, a * b);
        end
      end
    end
  endtask

  task automatic test_signed_8b();
    logic [7:0] av, bv;
    int errs;
    run_op(8'h80, 8'h80, 1'b1, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0);
    tests++;
    if (timeout || got24 != 16384 || lat != 4 || low_cnt != 4) begin
      fails++; $display("FAIL s8_80x80 got %0d lat %0d low %0d want 16384 4 4", got24, lat, low_cnt);
    end
    run_op(8'h80, 8'h7F, 1'b1, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0);
    tests++;
    if (timeout || got24 != -16256) begin fails++; $display("FAIL s8_80x7f got %0d want -16256", got24); end
    errs = 0;
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        av = {4'($urandom), 4'(a)};
        bv = {4'($urandom), 4'(b)};
        run_op(av, bv, 1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 1'b0);
        tests++;
        if (timeout || got24 != longint'(a * b) || lat != 2) begin
          fails++; errs++;
          if (errs < 5) $display("FAIL s4_sweep %0dx%0d got %0d want %0d", a, b, got24, a * b);
        end
      end
    end
  endtask

  task automatic test_mixed();
    logic [7:0] av;
    for (int i = 0; i < 4; i++) begin
      av = {6'($urandom), 2'b10};
      run_op(av, 8'd200, 1'b1, 1'b0, 2'd0, (i[0] ? 2'd3 : 2'd2), 1'b1, 1'b0);
      tests++;
      if (timeout || got24 != -400 || lat != 1 || low_cnt != 1) begin
        fails++; $display("FAIL mixed in=%h got %0d lat %0d want -400 lat 1", av, got24, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int extra;
    logic [23:0] held;
    run_op(8'd3, 8'd4, 1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1);
    tests++;
    if (timeout || got24 != 12) begin fails++; $display("FAIL acc_op1 got %0d want 12", got24); end
    run_op(8'd5, 8'hFA, 1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b1);
    tests++;
    if (timeout || got24 != -18 || ready_at_start !== 1'b1 || valid_at_start !== 1'b0) begin
      fails++; $display("FAIL acc_op2 got %0d rdy %b vld %b want -18 1 0", got24, ready_at_start, valid_at_start);
    end
    run_op(8'hF9, 8'hF9, 1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b1);
    in_valid = 1'b0;
    tests++;
    if (timeout || got24 != 31 || valid_at_start !== 1'b0) begin
      fails++; $display("FAIL acc_op3 got %0d vld %b want 31 0", got24, valid_at_start);
    end
    held = psum;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (psum_valid || psum !== held) extra++;
    end
    tests++;
    if (extra != 0) begin fails++; $display("FAIL acc_tail extra events %0d want 0", extra); end
  endtask

  task automatic test_overflow();
    longint want3;
`ifdef BITFUSION_SAT_EN
    want3 = 32767;
`else
    want3 = -17149;
`endif
    run_op(8'd127, 8'd127, 1'b1, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0);
    tests++;
    if (timeout || got16 != 16129) begin fails++; $display("FAIL ovf_1 got %0d want 16129", got16); end
    run_op(8'd127, 8'd127, 1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0);
    tests++;
    if (timeout || got16 != 32258) begin fails++; $display("FAIL ovf_2 got %0d want 32258", got16); end
    run_op(8'd127, 8'd127, 1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0);
    tests++;
    if (timeout || got16 != want3) begin fails++; $display("FAIL ovf_3 got %0d want %0d", got16, want3); end
  endtask

  task automatic test_reset_mid();
    int seen;
    run_op(8'd9, 8'd9, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0);
    in_op = 8'h55; weight = 8'h33; s_in = 1'b0; s_weight = 1'b0;
    prec_in = 2'd2; prec_weight = 2'd2; acc_clear = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    tests++;
    if (psum !== 24'd0 || in_ready !== 1'b1 || psum_valid !== 1'b0) begin
      fails++; $display("FAIL rst_mid psum %0d rdy %b vld %b want 0 1 0", psum, in_ready, psum_valid);
    end
    @(negedge clk) rst = 1'b0;
    exp24 = 0; exp16 = 0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (psum_valid) seen++;
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL rst_mid_valid got %0d pulses want 0", seen); end
    run_op(8'd2, 8'd3, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
    tests++;
    if (timeout || got24 != 6) begin fails++; $display("FAIL rst_next got %0d want 6", got24); end
  endtask

  task automatic test_random();
    logic [1:0] pa;
    int errs;
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      pa = 2'($urandom);
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), pa, 2'($urandom),
             ($urandom_range(0, 3) == 0), 1'($urandom));
      tests++;
      if (timeout || got24 != exp24 || got16 != exp16 || lat != prec_w(pa) / 2 ||
          low_cnt != lat || ready_at_start !== 1'b1 || valid_at_start !== 1'b0) begin
        fails++; errs++;
        if (errs < 5) $display("FAIL random #%0d got %0d/%0d lat %0d want %0d/%0d lat %0d",
                               i, got24, got16, lat, exp24, exp16, prec_w(pa) / 2);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned_4b();
    test_signed_8b();
    test_mixed();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bitfusion_mac.md
# bitfusion_mac

Parametrised, precision-configurable multiply-accumulate unit; successor to the fixed 4-bit `bitfusion_top` multiplier. It fuses a single 2-bit-slice BitBrick datapath over time to multiply 2-, 4- or 8-bit operands, with independent signed/unsigned control per operand. Products are accumulated into a wide partial sum. The unit sits between the operand buffers and the psum write-back path of a Bit Fusion PE.

## Interface
- `MAX_BITS`, 8, maximum operand width; even, ≥ 2.
- `ACC_W`, 24, accumulator width; ≥ 2*MAX_BITS.
- `CLK_125MHZ_FPGA`  in  1  single clock; all state is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  unit can accept an operand pair.
- `in`  in  MAX_BITS  activation operand; active bits are LSB-aligned.
- `weight`  in  MAX_BITS  weight operand; active bits are LSB-aligned.
- `s_in`  in  1  1 = `in` is two's complement.
- `s_weight`  in  1  1 = `weight` is two's complement.
- `prec_in`  in  2  `in` width: 0=2b, 1=4b, 2=8b, 3=MAX_BITS.
- `prec_weight`  in  2  `weight` width, same encoding.
- `acc_clear`  in  1  1 = product replaces the accumulator instead of adding to it.
- `psum`  out  ACC_W  accumulator, two's complement.
- `psum_valid`  out  1  one-cycle pulse on each `psum` update.

## Operation
- Precision codes above MAX_BITS clamp to MAX_BITS.
- N = (active `in` width)/2 slices.
- Handshake: transfer occurs on an edge where `in_valid` && `in_ready`. All operand and control inputs are sampled on that edge only and ignored otherwise.
- FSM states:
  - IDLE: `in_ready`=1. On transfer, move to BUSY, set slice counter to 0 and clear the product register.
  - BUSY: `in_ready`=0. One slice per edge. After slice N-1, update `psum`, pulse `psum_valid`, return to IDLE.
- Operands: bits above the active width are ignored. The active field is sign-extended if its signed flag is set, else zero-extended to MAX_BITS+1.
- Slice k multiplies `in[2k+1:2k]` by the extended weight:
  - The slice is unsigned, except the top slice (k=N-1) when `s_in`=1, which is signed (-2..1).
  - The partial product is shifted left 2k and added into a 2*MAX_BITS+2-bit product register.
- Accumulate: `psum` <= (`acc_clear` ? 0 : `psum`) + product sign-extended to ACC_W. Overflow behaviour is set by the Configuration section.
- Reset at any point, including mid-BUSY: abort the operation, state IDLE, `psum`=0, `psum_valid`=0, `in_ready`=1 once `rst` deasserts. The aborted product is discarded.

## Timing
- Reset values: `in_ready`=1, `psum`=0, `psum_valid`=0, state IDLE, counter 0, product register 0.
- Cycle sequence for a transfer at edge t:
  - Slices are processed at edges t+1..t+N.
  - `psum` is written at edge t+N. `psum_valid`=1 and `in_ready`=1 during the following cycle.
- Latency is N cycles: 1/2/4 cycles for 2/4/8-bit `in`. Latency is independent of `prec_weight`.
- Back-to-back: the next transfer can occur at edge t+N+1, giving throughput of one operation per N+1 cycles.
- `psum` holds between updates. `psum_valid` is never high for two consecutive cycles.

## Configuration
- `BITFUSION_SAT_EN` defined:
  - The accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - A positive overflow clamps to the maximum; a negative overflow clamps to the minimum.
- `BITFUSION_SAT_EN` undefined: the accumulate wraps modulo 2^ACC_W. No clamp logic is synthesised.

## Test plan
- 4b unsigned, `acc_clear`=1, in=15, weight=15 -> `psum`=225, `psum_valid` 2 cycles after transfer, `in_ready` low for exactly 2 cycles. Sweep all 16×16 pairs and check every product.
- 8b signed, in=0x80, weight=0x80 -> `psum`=16384, latency 4. Also in=0x80, weight=0x7F -> `psum`=-16256. Sweep all signed 4b pairs (-8..7) with no mismatches.
- Mixed precision: `prec_in`=0 signed in=2'b10 (-2), `prec_weight`=2 unsigned weight=200 -> `psum`=-400, latency 1. Junk placed in the ignored high bits of `in` has no effect.
- Accumulation: (3,4) with `acc_clear`=1, then (5,-6), then (-7,-7), all 4b signed, transfers back-to-back -> `psum` sequence 12, -18, 31. Exactly one `psum_valid` per operation. `in_valid` held high while `in_ready`=0 is not accepted twice.
- Overflow at ACC_W=16, 8b signed 127×127 three times, first with `acc_clear`=1 -> with `BITFUSION_SAT_EN`: 16129, 32258, 32767. Without it: 16129, 32258, -17149.
- Reset mid-op: assert `rst` asynchronously during the 2nd BUSY cycle of an 8b operation -> `psum`=0 and `in_ready`=1 immediately, no `psum_valid`. The next operation, (2,3) with `acc_clear`=0, gives `psum`=6.
